bus_sram_responder: RTL and testbench
=====================================

# bus_sram_responder

Memory-side responder for the core's data bus: accepts `rd_req`/`wr_req` transactions from the memory pipeline stage, inserts a configurable number of wait states via `rw_wait`, and services them from an internal word-organised synchronous RAM. It supports byte, halfword and word writes with lane selection. It returns full aligned words on reads, and the initiator performs the alignment and extension. It sits between the Memory stage bus port and on-chip RAM, and can stand in for the external memory model in simulation.

## Interface
- `DEPTH`, 4096: RAM size in 32-bit words; power of two.
- `WAIT_STATES`, 1: `rw_wait`-high cycles per transaction; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `busaddr`  in  32  byte address; word index = `busaddr[log2(DEPTH)+1:2]`; higher bits ignored (wrap).
- `rd_req`  in  1  read request; held by the initiator until it sees `rw_wait` low.
- `wr_req`  in  1  write request; held until `rw_wait` low.
- `data_size`  in  3  3'b001 byte, 3'b010 half, 3'b100 word.
- `wr_data`  in  32  write data, lane-positioned.
- `rd_data`  out  32  read word; valid in the completion cycle.
- `rw_wait`  out  1  combinational; high = transaction not complete this cycle.

## Operation
- States are IDLE, WAIT and DONE. The counter `cnt` is 4 bits.
- `req` = `rd_req | wr_req`. If both are high, the transaction is a read and the write is discarded.
- IDLE:
  - `rw_wait = req`.
  - On `req`: capture the kind (rd/wr) and the word index.
  - On a read, issue the RAM read.
  - Set `cnt = WAIT_STATES-1`.
  - Go to DONE if `cnt` was 0, else go to WAIT.
- WAIT:
  - `rw_wait = 1`; `cnt` decrements each cycle.
  - Go to DONE when `cnt` reaches 0.
- DONE, while `req` is high:
  - `rw_wait = 0`; this is the completion cycle.
  - A write commits at this edge.
  - Return to IDLE.
- Abort: if `req` is low in WAIT or DONE, the transaction is dropped. No write occurs, `rw_wait = 0`, and the next state is IDLE. This is the pipeline flush case.
- Retarget: if in WAIT or DONE the kind or word index differs from the captured value, treat it as abort plus new request. `rw_wait = 1`, and the next state is the same as from IDLE.
- Write lanes (a = `busaddr[1:0]`):
  - Byte: writes only lane a, from `wr_data[8a+7:8a]`.
  - Half: writes lanes {2,3} if `a[1]`, else {0,1}, from the same bit positions. `a[0]` is ignored.
  - Word: all four lanes.
  - Other `data_size` codes: no lanes written. The transaction still completes normally.
- Reads:
  - `rd_data` is the full word at the captured index, for every `data_size`.
  - `rd_data` is registered and holds its value until the next read's RAM access.
  - A read in DONE returns data including any write that committed earlier.
- Reset:
  - State goes to IDLE and `cnt` to 0.
  - The `rd_data` register clears to 0.
  - RAM contents are not reset.
  - `rw_wait` then follows `req`.
  - A transaction in flight when reset asserts is dropped; no write occurs.

## Timing
- A transaction occupies `WAIT_STATES+1` cycles of held request: `WAIT_STATES` cycles with `rw_wait=1`, then one completion cycle with `rw_wait=0`.
- Back-to-back transfers are allowed. A request still asserted in the cycle after completion, such as an LDM/STM burst with a new address, is a new transaction accepted in IDLE.
- A write followed immediately by a read of the same word returns the new data.
- `rw_wait` depends combinationally on `rd_req`, `wr_req`, `busaddr` and state only. It has no path from `wr_data` or `data_size`.

## Test plan
- Read after reset, WAIT_STATES=1:
  - Stimulus: RAM[0x10] preloaded with 0xDEADBEEF; hold `rd_req` with `busaddr=0x40`.
  - Required: `rw_wait` is 1 for one cycle, then 0; `rd_data=0xDEADBEEF` in the completion cycle.
- Word write then byte write:
  - Stimulus: word write 0x11223344 to 0x80, then byte write of `wr_data=0xAAAAAAAA` to 0x82, then read 0x80.
  - Required: the read returns 0x11AA3344.
- Halfword write with `a[0]` set:
  - Stimulus: half write of 0xBEEFBEEF to 0x83 over 0x00000000.
  - Required: RAM word = 0xBEEF0000.
- Abort mid-wait, WAIT_STATES=3:
  - Stimulus: assert `wr_req` to 0x100, then drop it after 2 cycles.
  - Required: no write occurs, the state returns to IDLE, and a later read of 0x100 returns the old value.
- Burst:
  - Stimulus: hold `rd_req` for 4 completions with `busaddr` 0x0, 0x4, 0x8, 0xC, advancing after each low `rw_wait`.
  - Required: 8 cycles total; data matches RAM[0..3].
- Asynchronous reset:
  - Stimulus: assert `rst` mid-write, between clock edges.
  - Required: `rd_data` goes to 0 immediately, the target word is unchanged, and `rw_wait` follows `req` once `rst` is released.

Source files
------------

// File: rtl/bus_sram_if.sv
// Data-bus port between the memory pipeline stage (master) and the SRAM responder (slave).
// The responder drives rw_wait combinationally from the request signals and its own state.
interface bus_sram_if;
   logic [31:0] busaddr;
   logic        rd_req;
   logic        wr_req;
   logic [2:0]  data_size;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rw_wait;

   modport master (
      output busaddr, rd_req, wr_req, data_size, wr_data,
      input  rd_data, rw_wait
   );

   modport slave (
      input  busaddr, rd_req, wr_req, data_size, wr_data,
      output rd_data, rw_wait
   );
endinterface

// File: rtl/bus_sram_responder.sv
// Wait-state inserting bus responder backed by a byte-lane word RAM.
// Reads return full aligned words; writes commit only in the completion cycle.
module bus_sram_responder #(
   parameter int DEPTH       = 4096,
   parameter int WAIT_STATES = 1
) (
   input  logic      clk,
   input  logic      rst,
   bus_sram_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state_reg;
   logic [3:0]      cnt_reg;
   logic            kind_rd_reg;
   logic [AW-1:0]   idx_reg;

   logic            req;
   logic            req_rd;
   logic [AW-1:0]   idx;
   logic            match;
   logic            start;
   logic            commit;
   logic            rw_wait_next;
   logic [3:0]      lane_en;
   logic [31:0]     rd_word;
   logic            unused_addr;

   assign req         = bus.rd_req | bus.wr_req;
   assign req_rd      = bus.rd_req;
   assign idx         = bus.busaddr[AW+1:2];
   assign match       = (req_rd == kind_rd_reg) && (idx == idx_reg);
   assign unused_addr = ^bus.busaddr[31:AW+2];

   // A changed kind or word index while busy is an abort followed by a fresh request.
   always_comb begin
      start        = 1'b0;
      rw_wait_next = 1'b0;
      case (state_reg)
         IDLE: begin
            start        = req;
            rw_wait_next = req;
         end
         WAIT: begin
            start        = req && !match;
            rw_wait_next = req;
         end
         DONE: begin
            start        = req && !match;
            rw_wait_next = req && !match;
         end
         default: begin
            start        = 1'b0;
            rw_wait_next = 1'b0;
         end
      endcase
   end

   assign bus.rw_wait = rw_wait_next;
   assign commit      = (state_reg == DONE) && req && match && !kind_rd_reg;

   always_comb begin
      lane_en = 4'b0000;
      case (bus.data_size)
         3'b001:  lane_en = 4'b0001 << bus.busaddr[1:0];
         3'b010:  lane_en = bus.busaddr[1] ? 4'b1100 : 4'b0011;
         3'b100:  lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= 4'd0;
         kind_rd_reg <= 1'b0;
         idx_reg     <= '0;
      end else if (start) begin
         kind_rd_reg <= req_rd;
         idx_reg     <= idx;
         cnt_reg     <= CNT_INIT;
         state_reg   <= (CNT_INIT == 4'd0) ? DONE : WAIT;
      end else begin
         case (state_reg)
            WAIT: begin
               if (!req) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
                  if (cnt_reg == 4'd1) begin
                     state_reg <= DONE;
                  end
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // One byte-wide RAM per lane so lane enables map onto independent write ports.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_reg;

         always_ff @(posedge clk) begin
            if (commit && lane_en[gi]) begin
               mem[idx_reg] <= bus.wr_data[8*gi +: 8];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_reg <= 8'd0;
            end else if (start && req_rd) begin
               rd_reg <= mem[idx];
            end
         end

         assign rd_word[8*gi +: 8] = rd_reg;
      end
   endgenerate

   assign bus.rd_data = rd_word;
endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench for bus_sram_responder: one instance with one wait state, one with three.
module tb_bus_sram_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_sram_if bus1 ();
   bus_sram_if bus3 ();

   bus_sram_responder #(.DEPTH(4096), .WAIT_STATES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   bus_sram_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.slave)
   );

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] rdat;
   int          cyc;
   int          hi;
   int          burst_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic drive(input bit which, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [2:0] sz, input logic [31:0] wd);
      if (which) begin
         bus3.rd_req = rd; bus3.wr_req = wr; bus3.busaddr = addr;
         bus3.data_size = sz; bus3.wr_data = wd;
      end else begin
         bus1.rd_req = rd; bus1.wr_req = wr; bus1.busaddr = addr;
         bus1.data_size = sz; bus1.wr_data = wd;
      end
   endtask

   task automatic idle(input bit which);
      drive(which, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
   endtask

   // Holds the request until rw_wait is seen low; the request is left asserted on return.
   task automatic xact(input bit which, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [2:0] sz, input logic [31:0] wd,
                       output logic [31:0] data, output int cycles, output int high);
      bit done;
      done   = 1'b0;
      cycles = 0;
      high   = 0;
      data   = 32'h0;
      drive(which, rd, wr, addr, sz, wd);
      while (!done && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if ((which ? bus3.rw_wait : bus1.rw_wait) === 1'b0) begin
            done = 1'b1;
            data = which ? bus3.rd_data : bus1.rd_data;
         end else begin
            high++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle(0);
      idle(1);

      // Reset state
      #2;
      check("rst_rd_data1", bus1.rd_data, 32'h0);
      check("rst_rd_data3", bus3.rd_data, 32'h0);
      check("rst_rw_wait_noreq", {31'h0, bus1.rw_wait}, 32'h0);
      bus1.rd_req = 1'b1;
      #1;
      check("rst_rw_wait_req", {31'h0, bus1.rw_wait}, 32'h1);
      idle(0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Preload then read 0x40 with one wait state
      xact(0, 0, 1, 32'h40, 3'b100, 32'hDEADBEEF, rdat, cyc, hi);
      check("wr_cycles", cyc, 2);
      idle(0);
      xact(0, 1, 0, 32'h40, 3'b100, 32'h0, rdat, cyc, hi);
      check("rd_high", hi, 1);
      check("rd_cycles", cyc, 2);
      check("rd_data_40", rdat, 32'hDEADBEEF);
      idle(0);

      // Word write, byte write, then immediate read of the same word
      xact(0, 0, 1, 32'h80, 3'b100, 32'h11223344, rdat, cyc, hi);
      xact(0, 0, 1, 32'h82, 3'b001, 32'hAAAAAAAA, rdat, cyc, hi);
      xact(0, 1, 0, 32'h80, 3'b001, 32'h0, rdat, cyc, hi);
      check("byte_merge", rdat, 32'h11AA3344);
      idle(0);

      // Halfword lanes, including an odd address
      xact(0, 0, 1, 32'hC0, 3'b100, 32'h00000000, rdat, cyc, hi);
      xact(0, 0, 1, 32'hC3, 3'b010, 32'hBEEFBEEF, rdat, cyc, hi);
      xact(0, 1, 0, 32'hC0, 3'b100, 32'h0, rdat, cyc, hi);
      check("half_upper", rdat, 32'hBEEF0000);
      xact(0, 0, 1, 32'hC4, 3'b100, 32'hFFFFFFFF, rdat, cyc, hi);
      xact(0, 0, 1, 32'hC4, 3'b010, 32'h12345678, rdat, cyc, hi);
      xact(0, 1, 0, 32'hC4, 3'b100, 32'h0, rdat, cyc, hi);
      check("half_lower", rdat, 32'hFFFF5678);

      // Illegal size completes but writes nothing
      xact(0, 0, 1, 32'hC0, 3'b011, 32'hFFFFFFFF, rdat, cyc, hi);
      check("badsize_cycles", cyc, 2);
      xact(0, 1, 0, 32'hC0, 3'b100, 32'h0, rdat, cyc, hi);
      check("badsize_nowrite", rdat, 32'hBEEF0000);
      idle(0);

      // Simultaneous rd_req and wr_req is a read
      xact(0, 1, 1, 32'h40, 3'b100, 32'h00000000, rdat, cyc, hi);
      check("both_is_read", rdat, 32'hDEADBEEF);
      xact(0, 1, 0, 32'h40, 3'b100, 32'h0, rdat, cyc, hi);
      check("both_no_write", rdat, 32'hDEADBEEF);
      idle(0);

      // Burst of four reads with the request held throughout
      for (int i = 0; i < 4; i++) begin
         xact(0, 0, 1, 32'(4 * i), 3'b100, 32'hC0DE0000 + 32'(i), rdat, cyc, hi);
      end
      idle(0);
      burst_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         xact(0, 1, 0, 32'(4 * i), 3'b100, 32'h0, rdat, cyc, hi);
         burst_cyc += cyc;
         check($sformatf("burst_data%0d", i), rdat, 32'hC0DE0000 + 32'(i));
      end
      idle(0);
      check("burst_cycles", burst_cyc, 8);

      // Three wait states: write, abort, retarget
      xact(1, 0, 1, 32'h100, 3'b100, 32'h55667788, rdat, cyc, hi);
      check("ws3_high", hi, 3);
      check("ws3_cycles", cyc, 4);
      idle(1);
      drive(1, 1'b0, 1'b1, 32'h100, 3'b100, 32'h99999999);
      @(negedge clk);
      check("abort_wait0", {31'h0, bus3.rw_wait}, 32'h1);
      @(negedge clk);
      check("abort_wait1", {31'h0, bus3.rw_wait}, 32'h1);
      @(posedge clk);
      #1;
      idle(1);
      @(negedge clk);
      check("abort_rw_low", {31'h0, bus3.rw_wait}, 32'h0);
      @(posedge clk);
      #1;
      xact(1, 1, 0, 32'h100, 3'b100, 32'h0, rdat, cyc, hi);
      check("abort_nowrite", rdat, 32'h55667788);
      check("abort_idle_high", hi, 3);
      idle(1);

      xact(1, 0, 1, 32'h104, 3'b100, 32'h0BADF00D, rdat, cyc, hi);
      idle(1);
      drive(1, 1'b0, 1'b1, 32'h104, 3'b100, 32'h12121212);
      @(posedge clk);
      #1;
      xact(1, 1, 0, 32'h100, 3'b100, 32'h0, rdat, cyc, hi);
      check("retarget_data", rdat, 32'h55667788);
      check("retarget_high", hi, 3);
      xact(1, 1, 0, 32'h104, 3'b100, 32'h0, rdat, cyc, hi);
      check("retarget_nowrite", rdat, 32'h0BADF00D);
      idle(1);

      // Asynchronous reset in the middle of a write
      drive(0, 1'b0, 1'b1, 32'h40, 3'b100, 32'hFFFFFFFF);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_rd_data", bus1.rd_data, 32'h0);
      check("arst_rw_follows", {31'h0, bus1.rw_wait}, 32'h1);
      @(posedge clk);
      #2;
      idle(0);
      rst = 1'b0;
      #1;
      check("arst_rw_idle", {31'h0, bus1.rw_wait}, 32'h0);
      @(posedge clk);
      #1;
      xact(0, 1, 0, 32'h40, 3'b100, 32'h0, rdat, cyc, hi);
      check("arst_nowrite", rdat, 32'hDEADBEEF);
      check("arst_high", hi, 1);
      idle(0);

      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
